// File: rtl/deconv_pkg.sv
// Shared types and width helpers for the deconvolution row issuer.
// Default geometry: 8-bit operands, 8 feature columns, 5 kernel taps.
package deconv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_BIT_WIDTH     = 32'd8;
  localparam int unsigned DEF_N_COL_FEATURE = 32'd8;
  localparam int unsigned DEF_N_COL_KERNEL  = 32'd5;

  localparam int unsigned N_PIX_IN = DEF_N_COL_FEATURE * DEF_N_COL_KERNEL;
  localparam int unsigned PROD_W   = 32'd2 * DEF_BIT_WIDTH;
  localparam int unsigned GROUP_W  = PROD_W * DEF_N_COL_KERNEL;
  localparam int unsigned BEAT_W   = $clog2(DEF_N_COL_FEATURE);

  function automatic int unsigned prod_width(input int unsigned bit_width);
    return 32'd2 * bit_width;
  endfunction

  // A single-column row still needs a 1-bit counter.
  function automatic int unsigned beat_width(input int unsigned n_col);
    if (n_col > 32'd1) begin
      return $clog2(n_col);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/row_multiplier.sv
// Combinational feature x kernel outer product, packed column-major by feature pixel.
// Each product is the full signed 2*BIT_WIDTH result.
module row_multiplier
  import deconv_pkg::*;
#(
  parameter int unsigned BIT_WIDTH     = DEF_BIT_WIDTH,
  parameter int unsigned N_COL_FEATURE = DEF_N_COL_FEATURE,
  parameter int unsigned N_COL_KERNEL  = DEF_N_COL_KERNEL
) (
  input  logic [BIT_WIDTH*N_COL_FEATURE-1:0]                       feature_row,
  input  logic [BIT_WIDTH*N_COL_KERNEL-1:0]                        kernel_row,
  output logic [prod_width(BIT_WIDTH)*N_COL_FEATURE*N_COL_KERNEL-1:0] products
);

  localparam int unsigned PROD_BITS = prod_width(BIT_WIDTH);

  for (genvar g = 0; g < N_COL_FEATURE; g++) begin : g_feat
    for (genvar j = 0; j < N_COL_KERNEL; j++) begin : g_kern
      logic signed [PROD_BITS-1:0] feat_ext_s;
      logic signed [PROD_BITS-1:0] kern_ext_s;
      logic signed [PROD_BITS-1:0] prod_s;

      // Sign-extend first so the low PROD_BITS of the product are exact.
      assign feat_ext_s = {{BIT_WIDTH{feature_row[g*BIT_WIDTH + BIT_WIDTH - 1]}},
                           feature_row[g*BIT_WIDTH +: BIT_WIDTH]};
      assign kern_ext_s = {{BIT_WIDTH{kernel_row[j*BIT_WIDTH + BIT_WIDTH - 1]}},
                           kernel_row[j*BIT_WIDTH +: BIT_WIDTH]};
      assign prod_s     = feat_ext_s * kern_ext_s;
      assign products[(g*N_COL_KERNEL + j)*PROD_BITS +: PROD_BITS] = prod_s;
    end
  end

endmodule

// File: rtl/deconv_row_issuer.sv
// Accepts a feature row and kernel row, registers their outer product, then issues
// one one-hot column strobe per feature pixel to the downstream shift/accumulate stage.
module deconv_row_issuer
  import deconv_pkg::*;
#(
  parameter int unsigned BIT_WIDTH     = DEF_BIT_WIDTH,
  parameter int unsigned N_COL_FEATURE = DEF_N_COL_FEATURE,
  parameter int unsigned N_COL_KERNEL  = DEF_N_COL_KERNEL,
  parameter int unsigned N_PIX_IN      = N_COL_FEATURE * N_COL_KERNEL,
  parameter int unsigned STRB_WIDTH    = 32'd2 * BIT_WIDTH * N_PIX_IN / 32'd4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [BIT_WIDTH*N_COL_FEATURE-1:0]   feature_row,
  input  logic [BIT_WIDTH*N_COL_KERNEL-1:0]    kernel_row,
  input  logic                                 out_ready,
  output logic                                 en_shift,
  output logic [STRB_WIDTH-1:0]                data_strobe,
  output logic [2*BIT_WIDTH*N_PIX_IN-1:0]      data_in,
  output logic                                 row_done,
  output logic                                 busy
);

  localparam int unsigned BEAT_BITS = beat_width(N_COL_FEATURE);
  localparam int unsigned DATA_BITS = 32'd2 * BIT_WIDTH * N_PIX_IN;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(N_COL_FEATURE - 32'd1);

  state_e                             state_r;
  state_e                             state_next_s;
  logic [BEAT_BITS-1:0]               beat_r;
  logic [BEAT_BITS-1:0]               beat_next_s;
  logic                               capture_s;
  logic [BIT_WIDTH*N_COL_FEATURE-1:0] feature_r;
  logic [BIT_WIDTH*N_COL_KERNEL-1:0]  kernel_r;
  logic [DATA_BITS-1:0]               products_s;
  logic [DATA_BITS-1:0]               data_in_r;
  logic [STRB_WIDTH-1:0]              strobe_next_s;
  logic [STRB_WIDTH-1:0]              data_strobe_r;
  logic                               en_shift_r;
  logic                               row_done_r;
  logic                               in_ready_r;
  logic                               busy_r;

  row_multiplier #(
    .BIT_WIDTH     (BIT_WIDTH),
    .N_COL_FEATURE (N_COL_FEATURE),
    .N_COL_KERNEL  (N_COL_KERNEL)
  ) u_row_multiplier (
    .feature_row (feature_r),
    .kernel_row  (kernel_r),
    .products    (products_s)
  );

  // Next-state, beat counter and next strobe pattern.
  always_comb begin
    state_next_s  = state_r;
    beat_next_s   = beat_r;
    capture_s     = 1'b0;
    strobe_next_s = '0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = MUL;
          capture_s    = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL: begin
        state_next_s = ISSUE;
        beat_next_s  = '0;
      end
      ISSUE: begin
        if (out_ready) begin
          if (beat_r == LAST_BEAT) begin
            state_next_s = DONE;
            beat_next_s  = '0;
          end else begin
            beat_next_s = beat_r + BEAT_BITS'(1);
          end
        end else begin
          beat_next_s = beat_r;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        beat_next_s  = '0;
      end
    endcase
    if (state_next_s == ISSUE) begin
      strobe_next_s[beat_next_s] = 1'b1;
    end else begin
      strobe_next_s = '0;
    end
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      beat_r  <= '0;
    end else begin
      state_r <= state_next_s;
      beat_r  <= beat_next_s;
    end
  end

  // Operand capture; held for the whole row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feature_r <= '0;
      kernel_r  <= '0;
    end else if (capture_s) begin
      feature_r <= feature_row;
      kernel_r  <= kernel_row;
    end else begin
      feature_r <= feature_r;
      kernel_r  <= kernel_r;
    end
  end

  // Product bus: loaded on MUL exit, deliberately kept through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in_r <= '0;
    end else if (state_r == MUL) begin
      data_in_r <= products_s;
    end else begin
      data_in_r <= data_in_r;
    end
  end

  // Handshake and beat outputs, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_shift_r    <= 1'b0;
      data_strobe_r <= '0;
      row_done_r    <= 1'b0;
      in_ready_r    <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      en_shift_r    <= (state_next_s == ISSUE);
      data_strobe_r <= strobe_next_s;
      row_done_r    <= (state_next_s == DONE);
      in_ready_r    <= (state_next_s == IDLE);
      busy_r        <= (state_next_s != IDLE);
    end
  end

  assign in_ready    = in_ready_r;
  assign en_shift    = en_shift_r;
  assign data_strobe = data_strobe_r;
  assign data_in     = data_in_r;
  assign row_done    = row_done_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_deconv_row_issuer.sv
// Directed bench for deconv_row_issuer: product layout, strobe sequencing,
// backpressure, back-to-back rows and mid-row reset.
module tb_deconv_row_issuer;

  localparam int BW   = 8;
  localparam int NF   = 8;
  localparam int NK   = 5;
  localparam int NPIX = NF * NK;
  localparam int SW   = 2 * BW * NPIX / 4;
  localparam int DW   = 2 * BW * NPIX;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [BW*NF-1:0] feature_row;
  logic [BW*NK-1:0] kernel_row;
  logic             out_ready;
  logic             en_shift;
  logic [SW-1:0]    data_strobe;
  logic [DW-1:0]    data_in;
  logic             row_done;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_accept = 0;
  int accept_period = 0;
  int n_accept = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] prev_data;

  deconv_row_issuer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .feature_row (feature_row),
    .kernel_row  (kernel_row),
    .out_ready   (out_ready),
    .en_shift    (en_shift),
    .data_strobe (data_strobe),
    .data_in     (data_in),
    .row_done    (row_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] prod(input int g, input int j);
    return data_in[(g*NK + j)*16 +: 16];
  endfunction

  // Cycle count, acceptance spacing and row_done pulses.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) begin
      accept_period = cyc - last_accept;
      last_accept   = cyc;
      n_accept++;
    end
    if (row_done) done_cnt++;
  end

  // Strobe invariants on every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check_val("strb_hi_zero", 64'(|data_strobe[SW-1:NF]), 64'd0);
      check_val("strb_onehot", 64'($onehot(data_strobe)), 64'(en_shift));
    end
  end

  task automatic run_row(input logic [63:0] f, input logic [39:0] k,
                         input int stall_beat, input int stall_len,
                         input bit chain, input logic [63:0] nf, input logic [39:0] nk,
                         input int exp_period);
    logic [DW-1:0] snap;
    in_valid    = 1'b1;
    feature_row = f;
    kernel_row  = k;
    out_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // MUL cycle
    if (chain) begin
      feature_row = nf;
      kernel_row  = nk;
    end else begin
      in_valid = 1'b0;
    end
    check_val("mul_in_ready", 64'(in_ready), 64'd0);
    check_val("mul_busy", 64'(busy), 64'd1);
    check_val("mul_en_shift", 64'(en_shift), 64'd0);
    check_val("mul_data_old", 64'(data_in == prev_data), 64'd1);
    if (exp_period != 0) check_val("row_period", 64'(accept_period), 64'(exp_period));
    @(negedge clk);
    snap = data_in;
    for (int b = 0; b < NF; b++) begin
      check_val("beat_en_shift", 64'(en_shift), 64'd1);
      check_val("beat_strobe", 64'(data_strobe[NF-1:0]), 64'(1 << b));
      check_val("beat_in_ready", 64'(in_ready), 64'd0);
      check_val("beat_data_hold", 64'(data_in == snap), 64'd1);
      if (b == stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check_val("stall_en_shift", 64'(en_shift), 64'd1);
          check_val("stall_strobe", 64'(data_strobe[NF-1:0]), 64'(1 << b));
          check_val("stall_data_hold", 64'(data_in == snap), 64'd1);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    // DONE cycle
    check_val("done_pulse", 64'(row_done), 64'd1);
    check_val("done_en_shift", 64'(en_shift), 64'd0);
    check_val("done_strobe", 64'(data_strobe[NF-1:0]), 64'd0);
    check_val("done_busy", 64'(busy), 64'd1);
    check_val("done_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    // IDLE cycle
    check_val("idle_row_done", 64'(row_done), 64'd0);
    check_val("idle_in_ready", 64'(in_ready), 64'd1);
    check_val("idle_busy", 64'(busy), 64'd0);
    check_val("idle_data_kept", 64'(data_in == snap), 64'd1);
    prev_data = snap;
  endtask

  initial begin
    int done_before;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    feature_row = '0;
    kernel_row  = '0;
    prev_data   = '0;
    repeat (2) @(negedge clk);
    check_val("rst_en_shift", 64'(en_shift), 64'd0);
    check_val("rst_strobe", 64'(|data_strobe), 64'd0);
    check_val("rst_data_in", 64'(|data_in), 64'd0);
    check_val("rst_row_done", 64'(row_done), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // 1: all-ones feature, kernel 1..5
    run_row({8{8'h01}}, {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, -1, 0, 1'b0, 64'd0, 40'd0, 0);
    for (int g = 0; g < NF; g++)
      for (int j = 0; j < NK; j++)
        check_val("ones_prod", 64'(prod(g, j)), 64'(j + 1));
    check_val("ones_done_cnt", 64'(done_cnt), 64'd1);

    // 2: sign extension and full-width products
    run_row({8'h7F, 48'h0, 8'h80}, {8'h7F, 16'h0, 8'h01, 8'h80}, -1, 0, 1'b0, 64'd0, 40'd0, 0);
    check_val("sign_p00", 64'(prod(0, 0)), 64'h4000);
    check_val("sign_p01", 64'(prod(0, 1)), 64'hFF80);
    check_val("sign_p04", 64'(prod(0, 4)), 64'hC080);
    check_val("sign_p74", 64'(prod(7, 4)), 64'h3F01);
    check_val("sign_p70", 64'(prod(7, 0)), 64'hC080);
    check_val("sign_p71", 64'(prod(7, 1)), 64'h007F);
    check_val("sign_p32", 64'(prod(3, 2)), 64'h0000);

    // 3: 3-cycle stall at beat 3, chained straight into row A
    run_row({8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, {5{8'hFF}},
            3, 3, 1'b1, {8{8'h02}}, {5{8'h03}}, 0);
    check_val("bp_p23", 64'(prod(2, 3)), 64'hFFFD);
    check_val("bp_p70", 64'(prod(7, 0)), 64'hFFF8);
    check_val("bp_p00", 64'(prod(0, 0)), 64'hFFFF);

    // 4: back-to-back rows A then B with in_valid held
    run_row({8{8'h02}}, {5{8'h03}}, -1, 0, 1'b1, {8{8'hFE}}, {5{8'h03}}, 14);
    check_val("b2b_a_p00", 64'(prod(0, 0)), 64'h0006);
    check_val("b2b_a_p74", 64'(prod(7, 4)), 64'h0006);
    run_row({8{8'hFE}}, {5{8'h03}}, -1, 0, 1'b0, 64'd0, 40'd0, 11);
    check_val("b2b_b_p00", 64'(prod(0, 0)), 64'hFFFA);
    check_val("b2b_b_p74", 64'(prod(7, 4)), 64'hFFFA);

    // 5: reset asserted at beat 5
    done_before = done_cnt;
    in_valid    = 1'b1;
    feature_row = {8{8'h05}};
    kernel_row  = {5{8'h05}};
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    check_val("abort_beat5", 64'(data_strobe[NF-1:0]), 64'h20);
    rst_n = 1'b0;
    #1;
    check_val("abort_en_shift", 64'(en_shift), 64'd0);
    check_val("abort_strobe", 64'(|data_strobe), 64'd0);
    check_val("abort_data_in", 64'(|data_in), 64'd0);
    check_val("abort_row_done", 64'(row_done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_in_ready", 64'(in_ready), 64'd1);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_no_done", 64'(done_cnt), 64'(done_before));
    prev_data = '0;

    run_row({8{8'h03}}, {5{8'hFD}}, -1, 0, 1'b0, 64'd0, 40'd0, 0);
    check_val("post_p00", 64'(prod(0, 0)), 64'hFFF7);
    check_val("post_p74", 64'(prod(7, 4)), 64'hFFF7);
    check_val("total_done", 64'(done_cnt), 64'd6);

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
